baud_tick_gen: RTL and testbench
================================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter DIV_W, default 16: width of the integer divisor.
REQ-002 Parameter FRAC_W, default 4: width of the fractional divisor, in units of 1/2^FRAC_W cycle.
REQ-003 Parameter OSR, default 16: oversample ticks per bit; legal range 2..256.
REQ-004 Parameter RST_INT, default 27: integer divisor loaded at reset.
REQ-005 Parameter RST_FRAC, default 2: fractional divisor loaded at reset (27+2/16 gives ~115200x16 at 50 MHz).
REQ-006 clk  in  1  system clock; all logic on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 en  in  1  count enable; low freezes the counters.
REQ-009 div_int  in  DIV_W  requested integer divisor (cycles per os_tick).
REQ-010 div_frac  in  FRAC_W  requested fractional divisor.
REQ-011 div_load  in  1  single-cycle strobe; captures div_int/div_frac into the pending register.
REQ-012 div_ack  out  1  single-cycle pulse in the cycle the pending divisor becomes active.
REQ-013 resync  in  1  single-cycle strobe; restarts the bit phase (RX start-bit alignment).
REQ-014 os_tick  out  1  single-cycle oversample tick.
REQ-015 bit_tick  out  1  single-cycle bit tick, coincident with every OSR-th os_tick.
REQ-016 os_phase  out  clog2(OSR)  index of the current oversample slot, 0..OSR-1.

Function
REQ-017 The block SHALL hold an active divisor (act_int, act_frac), a cycle counter cnt (DIV_W bits), a fraction accumulator acc (FRAC_W bits), a pending divisor register with a pend_valid flag, and a phase counter.
REQ-018 Period length SHALL be act_int cycles, plus one cycle when the previous os_tick's acc + act_frac addition produced a carry (extend flag).
REQ-019 When a 0 or 1 divisor is requested, act_int SHALL be used as 2.
REQ-020 os_tick SHALL assert for exactly one cycle when en=1 and cnt == period-1; in that cycle cnt <-0, {extend,acc} <- acc+act_frac, and the phase advances.
REQ-021 In steady state, long-run average os_tick spacing SHALL equal act_int + act_frac/2^FRAC_W cycles, and each interval SHALL be either act_int or act_int+1 cycles.
REQ-022 Otherwise, with en=1, cnt SHALL increment by one per cycle.
REQ-023 The phase SHALL wrap from OSR-1 to 0; bit_tick SHALL equal os_tick AND (phase == OSR-1); os_phase SHALL show the phase value before the increment.
REQ-024 div_load SHALL set pend_valid; a second div_load before the apply SHALL overwrite the pending value, with only one ack.
REQ-025 With en=1 and pend_valid, the pending value SHALL be applied in the next os_tick cycle; the new period starts immediately after that tick; div_ack pulses in that cycle.
REQ-026 A div_load in the same cycle as an os_tick SHALL be captured and applied on the following os_tick, not the current one.
REQ-027 With en=0 and pend_valid, the divisor SHALL be applied on the next clock edge, with div_ack one cycle after div_load.
REQ-028 Any divisor apply SHALL clear acc and extend.
REQ-029 With en=0, cnt, acc and phase SHALL hold, and os_tick and bit_tick SHALL stay 0.
REQ-030 resync SHALL clear cnt to OSR/2-aligned zero, acc, extend and phase to 0, and SHALL suppress os_tick/bit_tick that cycle.
REQ-031 resync SHALL take priority over a coincident tick; a pending apply SHALL be deferred to the next os_tick.
REQ-032 resync SHALL work regardless of en.
REQ-033 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-034 While rst=1: act_int=RST_INT, act_frac=RST_FRAC, cnt=0, acc=0, extend=0, phase=0, pend_valid=0, and os_tick, bit_tick, div_ack and os_phase are 0.
REQ-035 Deassertion SHALL be synchronised internally; the first os_tick SHALL occur RST_INT cycles after the first enabled edge following release.
REQ-036 Reset mid-period or with a pending load SHALL discard the pending value without a div_ack.

Verification
REQ-037 Defaults, en=1 for 2000 cycles -> os_tick intervals only 27 or 28 cycles; exactly 2 of every 16 intervals are 28; bit_tick every 16th os_tick.
REQ-038 div_load of int=10, frac=0 mid-period -> old period completes; div_ack with that os_tick; subsequent intervals all 10.
REQ-039 div_load coincident with os_tick -> apply and div_ack on the next os_tick, not the current one.
REQ-040 en=0 with div_load of int=5 -> div_ack the next cycle; no ticks while en=0; after en=1, first os_tick after 5 cycles.
REQ-041 resync at phase 7 coincident with an os_tick -> no tick that cycle; os_phase=0; bit_tick occurs 16 os_ticks later.
REQ-042 div_int=1 -> intervals of 2 cycles; rst asserted mid-period with pend_valid -> all outputs 0 and no div_ack.

Source files
------------

// File: rtl/baud_tick_if.sv
// Handshake and tick bundle between the baud tick generator and its UART client.
interface baud_tick_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
);
  localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;

  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              div_ack;
  logic              resync;
  logic              os_tick;
  logic              bit_tick;
  logic [PH_W-1:0]   os_phase;

  modport master (
    output en, div_int, div_frac, div_load, resync,
    input  div_ack, os_tick, bit_tick, os_phase
  );

  modport slave (
    input  en, div_int, div_frac, div_load, resync,
    output div_ack, os_tick, bit_tick, os_phase
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional-N oversample/bit tick generator with double-buffered divisor and
// bit-phase resync for UART RX alignment.
module baud_tick_gen #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int RST_INT  = 27,
  parameter int RST_FRAC = 2
) (
  input logic       clk,
  input logic       rst,
  baud_tick_if.slave bus
);
  localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PH_W-1:0]   PH_MAX = PH_W'(OSR - 1);
  localparam logic [DIV_W-1:0]  MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W:0]    ONE_P = (DIV_W+1)'(1);

  // Async assert, synchronous release of the internal reset.
  logic [1:0] rsync_q;
  logic       rst_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsync_q <= 2'b11;
    else     rsync_q <= {rsync_q[0], 1'b0};
  end
  assign rst_s = rsync_q[1];

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0]  pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic              os_tick_q, os_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              ack_q, ack_d;
  logic [PH_W-1:0]   os_phase_q, os_phase_d;

  logic [DIV_W:0] period;
  logic           tick, apply;

  assign period = {1'b0, act_int_q} + {{DIV_W{1'b0}}, ext_q};
  assign tick   = bus.en && !bus.resync && ({1'b0, cnt_q} == (period - ONE_P));
  // Enabled: swap on a tick; disabled: swap on the next edge. Resync defers it.
  assign apply  = pend_vld_q && !bus.resync && (bus.en ? tick : 1'b1);

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ext_d       = ext_q;
    ph_d        = ph_q;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_vld_d  = pend_vld_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;

    if (bus.en) cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d          = '0;
      {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, act_frac_q};
      ph_d           = (ph_q == PH_MAX) ? '0 : ph_q + 1'b1;
    end
    if (apply) begin
      act_int_d  = (pend_int_q < MIN_DIV) ? MIN_DIV : pend_int_q;
      act_frac_d = pend_frac_q;
      cnt_d      = '0;
      acc_d      = '0;
      ext_d      = 1'b0;
      pend_vld_d = 1'b0;
    end
    // A load coincident with an apply stays pending for the following tick.
    if (bus.div_load) begin
      pend_vld_d  = 1'b1;
      pend_int_d  = bus.div_int;
      pend_frac_d = bus.div_frac;
    end
    if (bus.resync) begin
      cnt_d = '0;
      acc_d = '0;
      ext_d = 1'b0;
      ph_d  = '0;
    end

    os_tick_d  = tick;
    bit_tick_d = tick && (ph_q == PH_MAX);
    ack_d      = apply;
    os_phase_d = bus.resync ? '0 : ph_q;
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      ext_q       <= 1'b0;
      ph_q        <= '0;
      act_int_q   <= DIV_W'(RST_INT);
      act_frac_q  <= FRAC_W'(RST_FRAC);
      pend_vld_q  <= 1'b0;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      os_tick_q   <= 1'b0;
      bit_tick_q  <= 1'b0;
      ack_q       <= 1'b0;
      os_phase_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ext_q       <= ext_d;
      ph_q        <= ph_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_vld_q  <= pend_vld_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      os_tick_q   <= os_tick_d;
      bit_tick_q  <= bit_tick_d;
      ack_q       <= ack_d;
      os_phase_q  <= os_phase_d;
    end
  end

  assign bus.os_tick  = os_tick_q;
  assign bus.bit_tick = bit_tick_q;
  assign bus.div_ack  = ack_q;
  assign bus.os_phase = os_phase_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: defaults, divisor swaps, resync and reset.
module tb_baud_tick_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  baud_tick_if #(.DIV_W(16), .FRAC_W(4), .OSR(16)) bus ();
  baud_tick_gen dut (.clk(clk), .rst(rst), .bus(bus));

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Count negedges until os_tick is seen; strobes auto-clear after one edge.
  task automatic wait_tick(output int cyc, output logic ack_at, output int ack_early,
                           output logic bt, output logic [3:0] ph);
    cyc = 0; ack_at = 1'b0; ack_early = 0; bt = 1'b0; ph = 4'd0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      bus.div_load = 1'b0;
      bus.resync   = 1'b0;
      if (bus.os_tick === 1'b1) begin
        ack_at = bus.div_ack; bt = bus.bit_tick; ph = bus.os_phase;
        return;
      end
      if (bus.div_ack === 1'b1) ack_early++;
    end
    cyc = -1;
  endtask

  int c, early, n28, bad, bterr, pherr, quiet;
  logic ack, bt;
  logic [3:0] ph;

  initial begin
    bus.en = 1'b0; bus.div_int = '0; bus.div_frac = '0;
    bus.div_load = 1'b0; bus.resync = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_os_tick", bus.os_tick, 0);
    check("rst_bit_tick", bus.bit_tick, 0);
    check("rst_div_ack", bus.div_ack, 0);
    check("rst_os_phase", bus.os_phase, 0);
    rst = 1'b0;
    quiet = 0;
    repeat (5) begin @(negedge clk); if (bus.os_tick !== 1'b0) quiet++; end
    check("idle_no_tick", quiet, 0);

    // Defaults 27 + 2/16
    bus.en = 1'b1;
    wait_tick(c, ack, early, bt, ph);
    check("first_tick_27", c, 27);
    check("first_tick_phase", ph, 0);
    n28 = 0; bad = 0; bterr = 0; pherr = 0;
    for (int k = 2; k <= 65; k++) begin
      wait_tick(c, ack, early, bt, ph);
      if (c == 28) n28++;
      else if (c != 27) bad++;
      if (bt !== ((k % 16) == 0)) bterr++;
      if (ph !== 4'((k - 1) % 16)) pherr++;
    end
    check("frac_bad_intervals", bad, 0);
    check("frac_n28_of_64", n28, 8);
    check("bit_tick_every_16", bterr, 0);
    check("os_phase_seq", pherr, 0);

    // Load 10/0 mid-period: old period completes, ack with its tick
    bus.div_int = 16'd10; bus.div_frac = 4'd0; bus.div_load = 1'b1;
    wait_tick(c, ack, early, bt, ph);
    check("load_old_period", c, 27);
    check("load_ack_at_tick", ack, 1);
    check("load_no_early_ack", early, 0);
    wait_tick(c, ack, early, bt, ph);
    check("div10_interval_a", c, 10);
    check("div10_no_ack", ack, 0);
    wait_tick(c, ack, early, bt, ph);
    check("div10_interval_b", c, 10);

    // Load coincident with a tick is applied on the following tick
    repeat (9) @(negedge clk);
    bus.div_int = 16'd6; bus.div_load = 1'b1;
    wait_tick(c, ack, early, bt, ph);
    check("coinc_tick_now", c, 1);
    check("coinc_no_ack_now", ack, 0);
    wait_tick(c, ack, early, bt, ph);
    check("coinc_old_period", c, 10);
    check("coinc_ack_next", ack, 1);
    wait_tick(c, ack, early, bt, ph);
    check("div6_interval", c, 6);

    // Disabled load of 5: ack next cycle, no ticks, first tick 5 after enable
    bus.en = 1'b0; bus.div_int = 16'd5; bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    check("en0_ack_not_yet", bus.div_ack, 0);
    @(negedge clk);
    check("en0_ack_next_cycle", bus.div_ack, 1);
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.os_tick !== 1'b0 || bus.bit_tick !== 1'b0 || bus.div_ack !== 1'b0) quiet++;
    end
    check("en0_quiet", quiet, 0);
    bus.en = 1'b1;
    wait_tick(c, ack, early, bt, ph);
    check("en1_first_tick_5", c, 5);
    wait_tick(c, ack, early, bt, ph);
    check("div5_interval", c, 5);

    // Resync at phase 7 coincident with a tick
    bus.resync = 1'b1;
    @(negedge clk);
    bus.resync = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wait_tick(c, ack, early, bt, ph);
      if (k == 0) check("resync0_phase0", ph, 0);
    end
    check("phase6_before_resync", ph, 6);
    repeat (4) @(negedge clk);
    bus.resync = 1'b1;
    @(negedge clk);
    bus.resync = 1'b0;
    check("resync_no_tick", bus.os_tick, 0);
    check("resync_no_bit_tick", bus.bit_tick, 0);
    check("resync_phase0", bus.os_phase, 0);
    bterr = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(c, ack, early, bt, ph);
      if (k == 1) check("resync_first_interval", c, 5);
      if (k < 16 && bt !== 1'b0) bterr++;
    end
    check("resync_no_early_bit_tick", bterr, 0);
    check("resync_bit_tick_16th", bt, 1);
    check("resync_phase15", ph, 15);

    // div_int=1 clamps to 2
    bus.div_int = 16'd1; bus.div_load = 1'b1;
    wait_tick(c, ack, early, bt, ph);
    check("clamp_old_period", c, 5);
    check("clamp_ack", ack, 1);
    wait_tick(c, ack, early, bt, ph);
    check("clamp_interval_a", c, 2);
    wait_tick(c, ack, early, bt, ph);
    check("clamp_interval_b", c, 2);

    // Reset with a pending load discards it without ack
    bus.div_int = 16'd9; bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    rst = 1'b1; bus.en = 1'b0;
    #1;
    check("midrst_os_tick", bus.os_tick, 0);
    check("midrst_bit_tick", bus.bit_tick, 0);
    check("midrst_div_ack", bus.div_ack, 0);
    check("midrst_os_phase", bus.os_phase, 0);
    quiet = 0;
    repeat (3) begin @(negedge clk); if (bus.div_ack !== 1'b0) quiet++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.div_ack !== 1'b0) quiet++; end
    check("midrst_no_ack", quiet, 0);
    bus.en = 1'b1;
    wait_tick(c, ack, early, bt, ph);
    check("postrst_tick_27", c, 27);
    check("postrst_no_ack", ack | (early != 0), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
